tdm_demux4_rst: RTL and testbench

Receive-side counterpart of the 4:1 reset-capable multiplexer. It takes a time-division stream, one channel sample per valid beat with a sync flag marking channel a, and distributes each sample to one of four registered outputs. A two-state frame tracker keeps the slot counter aligned to the sync flag and flags misalignment. The block sits at the far end of the select/serialise path, between the link and the per-channel consumers.

---
 rtl/tdm_demux4_rst_pkg.sv | 19 +
 rtl/tdm_demux4_rst_slot_counter.sv | 29 ++
 rtl/tdm_demux4_rst.sv | 103 ++++++++++
 tb/tb_tdm_demux4_rst.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/tdm_demux4_rst_pkg.sv
// Shared constants for the 4-channel TDM receive demultiplexer.
package tdm_demux4_rst_pkg;
  localparam int WIDTH_DEF = 1;

  // Frame tracker states
  localparam logic ST_HUNT   = 1'b0;
  localparam logic ST_LOCKED = 1'b1;

  // Slot indices within a frame
  localparam logic [1:0] SLOT_A = 2'd0;
  localparam logic [1:0] SLOT_B = 2'd1;
  localparam logic [1:0] SLOT_C = 2'd2;
  localparam logic [1:0] SLOT_D = 2'd3;

  // One-hot strobe for a given slot
  function automatic logic [3:0] slot_onehot(input logic [1:0] slot);
    slot_onehot = 4'b0001 << slot;
  endfunction
endpackage

// File: rtl/tdm_demux4_rst_slot_counter.sv
// 2-bit slot counter: load-to-1 on a sync beat, increment on a data beat.
module tdm_slot_counter
  import tdm_demux4_rst_pkg::*;
(
  input  logic       clk,
  input  logic       rs,
  input  logic       load,
  input  logic       inc,
  output logic [1:0] cnt,
  output logic       wrap
);
  logic [1:0] cnt_q, cnt_d;

  // Next count: load wins over increment; natural 2-bit wrap 3->0
  always_comb begin
    cnt_d = cnt_q;
    if (load)     cnt_d = SLOT_B;
    else if (inc) cnt_d = cnt_q + 2'd1;
  end

  // Counter register with synchronous reset
  always_ff @(posedge clk) begin
    if (rs) cnt_q <= SLOT_A;
    else    cnt_q <= cnt_d;
  end

  assign cnt  = cnt_q;
  assign wrap = (cnt_q == SLOT_D);
endmodule

// File: rtl/tdm_demux4_rst.sv
// 4-channel TDM receive demux with sync-aligned frame tracker.
module tdm_demux4_rst
  import tdm_demux4_rst_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rs,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  input  logic             i_sync,
  output logic [WIDTH-1:0] o_a,
  output logic [WIDTH-1:0] o_b,
  output logic [WIDTH-1:0] o_c,
  output logic [WIDTH-1:0] o_d,
  output logic [3:0]       o_strb,
  output logic             o_frame,
  output logic             o_err,
  output logic             o_locked
);
  logic             state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic [3:0]       strb_q, strb_d;
  logic             frame_q, frame_d, err_q, err_d;
  logic             cnt_load, cnt_inc, cnt_wrap;
  logic [1:0]       cnt;

  tdm_slot_counter u_cnt (
    .clk  (clk),
    .rs   (rs),
    .load (cnt_load),
    .inc  (cnt_inc),
    .cnt  (cnt),
    .wrap (cnt_wrap)
  );

  // Frame tracker and per-beat capture decisions; pulses default low
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    d_d      = d_q;
    strb_d   = 4'b0000;
    frame_d  = 1'b0;
    err_d    = 1'b0;
    cnt_load = 1'b0;
    cnt_inc  = 1'b0;
    if (i_valid) begin
      if (i_sync) begin
        // Sync always restarts the frame at slot a; off-slot sync is an error
        // only once locked (in HUNT this is simply the acquisition beat).
        a_d      = i_data;
        strb_d   = slot_onehot(SLOT_A);
        cnt_load = 1'b1;
        state_d  = ST_LOCKED;
        err_d    = (state_q == ST_LOCKED) && (cnt != SLOT_A);
      end else if (state_q == ST_LOCKED) begin
        unique case (cnt)
          SLOT_A: a_d = i_data;
          SLOT_B: b_d = i_data;
          SLOT_C: c_d = i_data;
          default: d_d = i_data;
        endcase
        strb_d  = slot_onehot(cnt);
        cnt_inc = 1'b1;
        frame_d = cnt_wrap;
      end
    end
  end

  // Output and state registers; reset discards any partial frame
  always_ff @(posedge clk) begin
    if (rs) begin
      state_q <= ST_HUNT;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      strb_q  <= 4'b0000;
      frame_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
      strb_q  <= strb_d;
      frame_q <= frame_d;
      err_q   <= err_d;
    end
  end

  assign o_a      = a_q;
  assign o_b      = b_q;
  assign o_c      = c_q;
  assign o_d      = d_q;
  assign o_strb   = strb_q;
  assign o_frame  = frame_q;
  assign o_err    = err_q;
  assign o_locked = (state_q == ST_LOCKED);
endmodule

// File: tb/tb_tdm_demux4_rst.sv
// Self-checking bench for tdm_demux4_rst: directed scenarios plus random traffic.
module tb_tdm_demux4_rst;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rs = 1'b0, i_valid = 1'b0, i_sync = 1'b0;
  logic [W-1:0] i_data = '0;
  logic [W-1:0] o_a, o_b, o_c, o_d;
  logic [3:0]   o_strb;
  logic         o_frame, o_err, o_locked;

  int n_chk = 0, n_pass = 0;

  // Reference model: frame-level view of the receiver
  logic [W-1:0] m_ch [4];
  logic [3:0]   m_strb;
  logic         m_frame, m_err, m_locked;
  int           m_slot;

  tdm_demux4_rst #(.WIDTH(W)) dut (
    .clk(clk), .rs(rs), .i_data(i_data), .i_valid(i_valid), .i_sync(i_sync),
    .o_a(o_a), .o_b(o_b), .o_c(o_c), .o_d(o_d), .o_strb(o_strb),
    .o_frame(o_frame), .o_err(o_err), .o_locked(o_locked)
  );

  always #5 clk = ~clk;

  wire [4*W+6:0] dut_vec = {o_a, o_b, o_c, o_d, o_strb, o_frame, o_err, o_locked};
  wire [4*W+6:0] exp_vec = {m_ch[0], m_ch[1], m_ch[2], m_ch[3], m_strb, m_frame, m_err, m_locked};

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_ch[i] = '0;
    m_strb = 4'b0; m_frame = 0; m_err = 0; m_locked = 0; m_slot = 0;
  endtask

  // Apply one beat for one clock; update the model at the edge, return 1ns later
  task automatic cyc(input logic r, input logic v, input logic s, input logic [W-1:0] d);
    @(negedge clk);
    rs = r; i_valid = v; i_sync = s; i_data = d;
    @(posedge clk);
    if (r) model_reset();
    else begin
      m_strb = 4'b0; m_frame = 0; m_err = 0;
      if (v) begin
        if (s) begin
          m_err    = m_locked && (m_slot != 0);
          m_ch[0]  = d;
          m_strb   = 4'b0001;
          m_slot   = 1;
          m_locked = 1;
        end else if (m_locked) begin
          m_ch[m_slot] = d;
          m_strb  = 4'(1 << m_slot);
          m_frame = (m_slot == 3);
          m_slot  = (m_slot + 1) % 4;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      cyc(1, 1, 1, 8'd1);
      n_chk++;
      if (dut_vec !== {(4*W+7){1'b0}}) $display("FAIL reset_hold%0d got=%h exp=0", i, dut_vec);
      else n_pass++;
    end
    cyc(0, 0, 0, 8'd0);
    n_chk++;
    if (dut_vec !== {(4*W+7){1'b0}} || o_locked !== 1'b0)
      $display("FAIL reset_release got=%h exp=0", dut_vec);
    else n_pass++;
  endtask

  task automatic test_clean_frame();
    logic [3:0] exp_s [4];
    logic [W-1:0] dv [4];
    int frames;
    exp_s[0] = 4'b0001; exp_s[1] = 4'b0010; exp_s[2] = 4'b0100; exp_s[3] = 4'b1000;
    dv[0] = 8'd1; dv[1] = 8'd0; dv[2] = 8'd0; dv[3] = 8'd1;
    frames = 0;
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, (i == 0), dv[i]);
      frames += int'(o_frame);
      n_chk++;
      if (o_strb !== exp_s[i] || o_frame !== (i == 3) || dut_vec !== exp_vec)
        $display("FAIL clean_beat%0d strb=%b frame=%b got=%h exp=%h", i, o_strb, o_frame, dut_vec, exp_vec);
      else n_pass++;
    end
    cyc(0, 0, 0, 0);
    frames += int'(o_frame);
    n_chk++;
    if (o_a !== 8'd1 || o_b !== 8'd0 || o_c !== 8'd0 || o_d !== 8'd1 || frames != 1 || o_strb !== 4'b0)
      $display("FAIL clean_final a=%h b=%h c=%h d=%h frames=%0d exp 1 0 0 1 frames=1", o_a, o_b, o_c, o_d, frames);
    else n_pass++;
  endtask

  task automatic test_hunt_drop();
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 8'(8'h55 + i));
      n_chk++;
      if (o_strb !== 4'b0 || o_locked !== 1'b0 || dut_vec !== exp_vec)
        $display("FAIL hunt_drop%0d strb=%b locked=%b exp strb=0 locked=0", i, o_strb, o_locked);
      else n_pass++;
    end
    cyc(0, 1, 1, 8'd1);
    n_chk++;
    if (o_a !== 8'd1 || o_locked !== 1'b1 || o_strb !== 4'b0001)
      $display("FAIL hunt_lock a=%h locked=%b strb=%b exp a=1 locked=1 strb=0001", o_a, o_locked, o_strb);
    else n_pass++;
  endtask

  task automatic test_misalign();
    cyc(1, 0, 0, 0);
    cyc(0, 1, 1, 8'h11);
    cyc(0, 1, 0, 8'h22);
    cyc(0, 1, 1, 8'h00);
    n_chk++;
    if (o_err !== 1'b1 || o_strb !== 4'b0001 || o_a !== 8'h00 || o_b !== 8'h22 || o_frame !== 1'b0)
      $display("FAIL misalign_err err=%b strb=%b a=%h b=%h exp err=1 strb=0001 a=00 b=22", o_err, o_strb, o_a, o_b);
    else n_pass++;
    cyc(0, 1, 0, 8'h33);
    n_chk++;
    if (o_strb !== 4'b0010 || o_err !== 1'b0 || o_frame !== 1'b0 || o_b !== 8'h33)
      $display("FAIL misalign_next strb=%b err=%b b=%h exp strb=0010 err=0 b=33", o_strb, o_err, o_b);
    else n_pass++;
  endtask

  task automatic test_gaps_wrap();
    int frames;
    logic [W-1:0] d;
    frames = 0;
    cyc(1, 0, 0, 0);
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 4; i++) begin
        d = 8'(8'h40 + 16 * f + i);
        cyc(0, 1, (f == 0 && i == 0), d);
        frames += int'(o_frame);
        n_chk++;
        if (dut_vec !== exp_vec || o_strb !== 4'(1 << i))
          $display("FAIL gap_beat f%0d s%0d got=%h exp=%h", f, i, dut_vec, exp_vec);
        else n_pass++;
        if (f == 1 && i == 0) begin
          n_chk++;
          if (o_a !== 8'h50) $display("FAIL wrap_slot_a got=%h exp=50", o_a);
          else n_pass++;
        end
        for (int g = 0; g < 5; g++) begin
          cyc(0, 0, 0, 8'hFF);
          frames += int'(o_frame);
          n_chk++;
          if (dut_vec !== exp_vec || o_strb !== 4'b0)
            $display("FAIL gap_hold f%0d s%0d g%0d got=%h exp=%h", f, i, g, dut_vec, exp_vec);
          else n_pass++;
        end
      end
    end
    n_chk++;
    if (frames != 2) $display("FAIL gap_frames got=%0d exp=2", frames);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    cyc(1, 0, 0, 0);
    cyc(0, 1, 1, 8'hA1);
    cyc(0, 1, 0, 8'hB2);
    cyc(1, 0, 0, 0);
    n_chk++;
    if (dut_vec !== {(4*W+7){1'b0}}) $display("FAIL midrst_clear got=%h exp=0", dut_vec);
    else n_pass++;
    cyc(0, 1, 0, 8'hC3);
    n_chk++;
    if (o_strb !== 4'b0 || o_locked !== 1'b0 || o_a !== 8'h0 || o_b !== 8'h0)
      $display("FAIL midrst_ignore strb=%b locked=%b a=%h b=%h exp all 0", o_strb, o_locked, o_a, o_b);
    else n_pass++;
  endtask

  task automatic test_random();
    logic r, v, s;
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 99) < 2);
      v = ($urandom_range(0, 99) < 70);
      s = ($urandom_range(0, 99) < 20);
      cyc(r, v, s, 8'($urandom));
      n_chk++;
      if (dut_vec !== exp_vec) $display("FAIL random%0d got=%h exp=%h", i, dut_vec, exp_vec);
      else n_pass++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_clean_frame();
    test_hunt_drop();
    test_misalign();
    test_gaps_wrap();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
